store_write_buffer: RTL

//  Buffers aligned stores between the MEM stage and the data memory write port.

---
 rtl/store_write_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: byte-masks aligned stores from MEM, queues them in a small FIFO,
// and drains them to the data memory over a req/ack handshake. Also flags load/store word hazards.
module store_write_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              empty,
    output logic              misalign
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic [ADDR_W-3:0] r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [3:0]        r_be   [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PW:0]       r_count;
    logic              r_misalign;
    state_t            r_state, w_state_nxt;

    logic              w_push, w_pop, w_mis, w_hz;
    logic [3:0]        w_base, w_be;
    logic [PW:0]       w_count_nxt;
    logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;

    assign st_ready = (r_count < (PW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign misalign = r_misalign;
    assign w_push   = st_valid && st_ready;
    assign w_pop    = mem_req && mem_ack;

    // Shifting a 4-bit value clips the mask at the word boundary instead of wrapping.
    always_comb begin
        case (st_size)
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
        w_be  = w_base << st_addr[1:0];
        w_mis = ((st_size == 2'b01) && st_addr[0]) || (st_size[1] && (st_addr[1:0] != 2'b00));
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
        w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_vld      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_misalign <= w_push && w_mis;
            if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            if (w_pop)  r_vld[r_rd_ptr] <= 1'b0;
            if (w_push) r_vld[r_wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr[ADDR_W-1:2];
            r_data[r_wr_ptr] <= st_data;
            r_be[r_wr_ptr]   <= w_be;
        end
    end

    // Only already-buffered entries count; the store being pushed this cycle is not visible yet.
    always_comb begin
        w_hz = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (r_vld[i] && (r_addr[i] == ld_addr[ADDR_W-1:2])) w_hz = 1'b1;
    end
    assign ld_hazard = w_hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (w_count_nxt != '0) ? S_BUSY : S_IDLE;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (r_state == S_BUSY) begin
            mem_req   = 1'b1;
            mem_addr  = {r_addr[r_rd_ptr], 2'b00};
            mem_wdata = r_data[r_rd_ptr];
            mem_be    = r_be[r_rd_ptr];
        end
    end
endmodule
